// File: rtl/neuron_activation_unit_pkg.sv
// Shared defaults, activation-type names and the elaboration-time sigmoid
// helper for the neuron activation stage.
package neuron_activation_unit_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_WINT_W   = 1;
    localparam int DEF_SIG_SIZE = 5;
    localparam int DEF_FRAC     = DEF_DATA_W - 1 - DEF_WINT_W;

    localparam string ACT_RELU         = "relu";
    localparam string ACT_SIGMOID      = "sigmoid";
    localparam string ACT_SIGMOID_HALF = "sigmoid_half";

    // round-half-up of 2^frac / (1 + e^-x), x = k / 2^shift; e^|x| by Taylor
    // series so the table needs no math library at elaboration
    function automatic int sigmoid_entry(input int k, input int frac, input int shift);
        real x;
        real ax;
        real term;
        real e_pos;
        real e_neg;
        x     = real'(k) / real'(1 << shift);
        ax    = (x < 0.0) ? -x : x;
        term  = 1.0;
        e_pos = 1.0;
        for (int n = 1; n < 48; n++) begin
            term  = term * ax / real'(n);
            e_pos = e_pos + term;
        end
        e_neg = (x < 0.0) ? e_pos : 1.0 / e_pos;
        return $rtoi(real'(1 << frac) / (1.0 + e_neg) + 0.5);
    endfunction

endpackage

// File: rtl/act_sigmoid_lut.sv
// Sigmoid ROM with code saturation: full offset-binary table, or half table
// plus sigmoid(-x) = 1 - sigmoid(x) symmetry when HALF is set.
module act_sigmoid_lut
    import neuron_activation_unit_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WINT_W   = DEF_WINT_W,
    parameter int SIG_SIZE = DEF_SIG_SIZE,
    parameter bit HALF     = 1'b0
) (
    input  logic [WINT_W+SIG_SIZE-1:0] code_in,
    output logic [DATA_W-1:0]          act
);

    localparam int FRAC     = DATA_W - 1 - WINT_W;
    localparam int SHIFT    = SIG_SIZE - 2 - WINT_W;
    localparam int HALF_OFS = 2 ** (SIG_SIZE - 1);
    localparam int ENTRIES  = HALF ? HALF_OFS + 1 : 2 * HALF_OFS;

    typedef logic [ENTRIES-1:0][DATA_W-1:0] rom_t;

    function automatic rom_t build_rom();
        rom_t rom;
        for (int i = 0; i < ENTRIES; i++) begin
            rom[i] = DATA_W'(sigmoid_entry(HALF ? i : i - HALF_OFS, FRAC, SHIFT));
        end
        return rom;
    endfunction

    localparam rom_t ROM = build_rom();

    logic [WINT_W:0]     int_bits;
    logic                ovf;
    logic [SIG_SIZE-1:0] code;
    logic [SIG_SIZE-1:0] idx;
    logic [DATA_W-1:0]   entry;

    // NOTE: every always_comb output gets a value on every path (defaults
    // first) so no latch is inferred.
    always_comb begin
        idx      = '0;
        int_bits = code_in[WINT_W+SIG_SIZE-1 -: WINT_W+1];
        ovf      = !((&int_bits) || !(|int_bits));
        if (ovf) begin
            code = {int_bits[WINT_W], {(SIG_SIZE-1){~int_bits[WINT_W]}}};
        end else begin
            code = code_in[SIG_SIZE-1:0];
        end

        if (HALF) begin
            // magnitude of the most negative code is representable unsigned
            idx   = code[SIG_SIZE-1] ? -code : code;
            entry = ROM[idx];
            act   = code[SIG_SIZE-1] ? DATA_W'(1 << FRAC) - entry : entry;
        end else begin
            idx   = {~code[SIG_SIZE-1], code[SIG_SIZE-2:0]};
            entry = ROM[idx];
            act   = entry;
        end
    end

endmodule

// File: rtl/neuron_activation_unit.sv
// Registered activation stage of one neuron: ReLU, full sigmoid ROM or
// half sigmoid ROM, one cycle from in_valid to out_valid.
module neuron_activation_unit
    import neuron_activation_unit_pkg::*;
#(
    parameter int    DATA_W   = DEF_DATA_W,
    parameter int    WINT_W   = DEF_WINT_W,
    parameter int    SIG_SIZE = DEF_SIG_SIZE,
    parameter string ACT_TYPE = ACT_RELU
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   sum_in,
    output logic [DATA_W-1:0]     act_out,
    output logic                  out_valid
);

    localparam int FRAC        = DATA_W - 1 - WINT_W;
    localparam int MSB         = 2 * DATA_W - 1;
    localparam int RELU_OVF_LO = FRAC + DATA_W - 1;

    logic [DATA_W-1:0] act_fn;
    logic [DATA_W-1:0] act_d, act_q;
    logic              valid_d, valid_q;
    logic              unused_sum;

    assign unused_sum = ^sum_in;

    generate
        if (ACT_TYPE == ACT_RELU) begin : g_relu
            always_comb begin
                if (sum_in[MSB]) begin
                    act_fn = '0;
                end else if (|sum_in[MSB-1:RELU_OVF_LO]) begin
                    act_fn = {1'b0, {(DATA_W-1){1'b1}}};
                end else begin
                    act_fn = {1'b0, sum_in[RELU_OVF_LO-1:FRAC]};
                end
            end
        end else if (ACT_TYPE == ACT_SIGMOID) begin : g_sigmoid
            act_sigmoid_lut #(
                .DATA_W   (DATA_W),
                .WINT_W   (WINT_W),
                .SIG_SIZE (SIG_SIZE),
                .HALF     (1'b0)
            ) u_lut (
                .code_in (sum_in[MSB -: WINT_W+SIG_SIZE]),
                .act     (act_fn)
            );
        end else if (ACT_TYPE == ACT_SIGMOID_HALF) begin : g_sigmoid_half
            act_sigmoid_lut #(
                .DATA_W   (DATA_W),
                .WINT_W   (WINT_W),
                .SIG_SIZE (SIG_SIZE),
                .HALF     (1'b1)
            ) u_lut (
                .code_in (sum_in[MSB -: WINT_W+SIG_SIZE]),
                .act     (act_fn)
            );
        end else begin : g_bad_act_type
            $error("neuron_activation_unit: unsupported ACT_TYPE");
            assign act_fn = '0;
        end
    endgenerate

    always_comb begin
        act_d   = act_q;
        valid_d = in_valid;
        if (in_valid) begin
            act_d = act_fn;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            act_q   <= act_d;
            valid_q <= valid_d;
        end
    end

    assign act_out   = act_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_neuron_activation_unit.sv
// Bench for neuron_activation_unit: one instance per ACT_TYPE on shared
// inputs, compared against a real-arithmetic reference model.
module tb_neuron_activation_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] sum_in;
    logic [15:0] act_relu, act_sig, act_half;
    logic        val_relu, val_sig, val_half;

    int checks   = 0;
    int failures = 0;
    int exp_act [3];
    int exp_valid;

    always #5 clk = ~clk;

    neuron_activation_unit #(.ACT_TYPE("relu")) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum_in(sum_in),
        .act_out(act_relu), .out_valid(val_relu)
    );

    neuron_activation_unit #(.ACT_TYPE("sigmoid")) u_sig (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum_in(sum_in),
        .act_out(act_sig), .out_valid(val_sig)
    );

    neuron_activation_unit #(.ACT_TYPE("sigmoid_half")) u_half (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum_in(sum_in),
        .act_out(act_half), .out_valid(val_half)
    );

    // Reference model: values in real units (Q3.28 in, Q1.14 out).
    function automatic int relu_ref(input logic [31:0] s);
        int sv;
        int q;
        sv = signed'(s);
        if (sv < 0) return 0;
        q = sv / 16384;
        return (q > 32767) ? 32767 : q;
    endfunction

    function automatic int sig_code(input logic [31:0] s);
        int k;
        k = signed'(s) >>> 26;
        if (k > 15)  k = 15;
        if (k < -16) k = -16;
        return k;
    endfunction

    function automatic int sig_round(input int k);
        real r;
        r = 16384.0 / (1.0 + $exp(-real'(k) / 4.0));
        return int'($floor(r + 0.5));
    endfunction

    function automatic int half_ref(input int k);
        return (k >= 0) ? sig_round(k) : 16384 - sig_round(-k);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare all DUTs.
    task automatic step(input logic r, input logic v, input logic [31:0] s);
        rst      = r;
        in_valid = v;
        sum_in   = s;
        @(posedge clk);
        if (r) begin
            exp_act   = '{0, 0, 0};
            exp_valid = 0;
        end else begin
            exp_valid = int'(v);
            if (v) begin
                exp_act[0] = relu_ref(s);
                exp_act[1] = sig_round(sig_code(s));
                exp_act[2] = half_ref(sig_code(s));
            end
        end
        @(negedge clk);
        check("relu_act",  act_relu, 16'(exp_act[0]));
        check("sig_act",   act_sig,  16'(exp_act[1]));
        check("half_act",  act_half, 16'(exp_act[2]));
        check("relu_vld",  {15'd0, val_relu}, 16'(exp_valid));
        check("sig_vld",   {15'd0, val_sig},  16'(exp_valid));
        check("half_vld",  {15'd0, val_half}, 16'(exp_valid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        int          sel;

        rst = 1'b1; in_valid = 1'b0; sum_in = '0;
        exp_act = '{0, 0, 0};
        exp_valid = 0;
        @(negedge clk);

        step(1'b1, 1'b0, 32'h0);
        check("reset_act", act_sig, 16'd0);

        step(1'b0, 1'b1, 32'h1800_0000);
        check("relu_1p5", act_relu, 16'd24576);
        step(1'b0, 1'b1, 32'h3000_0000);
        check("relu_sat", act_relu, 16'd32767);
        step(1'b0, 1'b1, 32'hF000_0000);
        check("relu_neg", act_relu, 16'd0);

        step(1'b0, 1'b1, 32'h0000_0000);
        check("sig_zero",  act_sig,  16'd8192);
        check("half_zero", act_half, 16'd8192);
        step(1'b0, 1'b1, 32'h3C00_0000);
        check("sig_k15",  act_sig,  16'd16008);
        check("half_k15", act_half, 16'd16008);
        step(1'b0, 1'b1, 32'hC000_0000);
        check("sig_km16",  act_sig,  16'd295);
        check("half_km16", act_half, 16'd295);
        step(1'b0, 1'b1, 32'hFC00_0000);
        step(1'b0, 1'b1, 32'h0400_0000);

        step(1'b0, 1'b1, 32'h7FFF_FFFF);
        check("sig_ovf_pos",  act_sig,  16'd16008);
        check("half_ovf_pos", act_half, 16'd16008);
        step(1'b0, 1'b1, 32'h8000_0000);
        check("sig_ovf_neg",  act_sig,  16'd295);
        check("half_ovf_neg", act_half, 16'd295);

        // back-to-back valids, then holds with changing sum_in
        step(1'b0, 1'b1, 32'h0800_0000);
        step(1'b0, 1'b1, 32'hF800_0000);
        step(1'b0, 1'b1, 32'h1234_5678);
        step(1'b0, 1'b0, 32'h3C00_0000);
        step(1'b0, 1'b0, 32'hC000_0000);

        // reset wins over in_valid
        step(1'b0, 1'b1, 32'h1000_0000);
        step(1'b1, 1'b1, 32'h1000_0000);
        check("rst_mid_act", act_relu, 16'd0);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       s = $urandom;
                1:       s = {{4{$urandom_range(0, 1) == 1}}, 28'($urandom)};
                2:       s = {6'($urandom_range(0, 63)), 26'($urandom)};
                default: s = {{2{$urandom_range(0, 1) == 1}}, 30'($urandom)};
            endcase
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
